// File: rtl/carryskip_pipe_adder.sv
// Pipelined carry-skip adder/subtractor. Stage k resolves one SW-bit slice;
// the inter-slice carry, unused upper operands and finished lower sums are registered.
module carryskip_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int SW   = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;
    localparam int NGRP = (BLK >= 1) ? SW / BLK : 1;

    if (STAGES < 1 || BLK < 1 || (WIDTH % STAGES) != 0 || (SW % BLK) != 0) begin : g_bad_params
        $error("carryskip_pipe_adder: WIDTH must split into STAGES slices of whole BLK groups");
    end

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic                         ovf_q, ovf_d;
    logic                         adv;

    // Whole pipeline moves together; it only stalls when a held result is refused.
    always_comb begin
        adv = !valid_q[STAGES-1] || out_ready;
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign co        = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    // Per-stage slice evaluation: ripple inside each BLK group, skip across it on full propagate.
    always_comb begin
        logic [WIDTH-1:0] op_a, op_b, acc;
        logic             c, gc_in, rc, p, x, msb_cin;
        int               idx;
        op_a    = '0;
        op_b    = '0;
        acc     = '0;
        c       = 1'b0;
        gc_in   = 1'b0;
        rc      = 1'b0;
        p       = 1'b0;
        x       = 1'b0;
        msb_cin = 1'b0;
        idx     = 0;
        valid_d = '0;
        carry_d = '0;
        a_d     = '0;
        b_d     = '0;
        sum_d   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                op_a       = a;
                op_b       = b ^ {WIDTH{sub}};
                acc        = '0;
                c          = ci;
                valid_d[k] = in_valid;
            end else begin
                op_a       = a_q[k-1];
                op_b       = b_q[k-1];
                acc        = sum_q[k-1];
                c          = carry_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            for (int g = 0; g < NGRP; g++) begin
                gc_in = c;
                rc    = c;
                p     = 1'b1;
                for (int i = 0; i < BLK; i++) begin
                    idx      = k * SW + g * BLK + i;
                    x        = op_a[idx] ^ op_b[idx];
                    acc[idx] = x ^ rc;
                    if (idx == WIDTH - 1) begin
                        msb_cin = rc;
                    end else begin
                        msb_cin = msb_cin;
                    end
                    rc = (op_a[idx] & op_b[idx]) | (x & rc);
                    p  = p & x;
                end
                c = p ? gc_in : rc;
            end
            a_d[k]     = op_a;
            b_d[k]     = op_b;
            sum_d[k]   = acc;
            carry_d[k] = c;
        end
        ovf_d = msb_cin ^ carry_d[STAGES-1];
    end

    // Pipeline registers: cleared by reset, loaded on advance, held while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end else begin
            valid_q <= valid_q;
            carry_q <= carry_q;
            a_q     <= a_q;
            b_q     <= b_q;
            sum_q   <= sum_q;
            ovf_q   <= ovf_q;
        end
    end

endmodule

// File: tb/tb_carryskip_pipe_adder.sv
// Directed and scoreboard bench for the default 32-bit, 4-stage carry-skip adder.
module tb_carryskip_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        co;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    carryskip_pipe_adder #(.WIDTH(32), .BLK(4), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vci, input logic vsub,
                           input logic [31:0] es, input logic eco, input logic eovf);
        int cnt;
        a = va; b = vb; ci = vci; sub = vsub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 12) begin
            tick();
            cnt++;
        end
        check_val({tag, "_lat"}, 64'(cnt), 64'd4);
        check_val({tag, "_s"},   64'(s),   64'(es));
        check_val({tag, "_co"},  64'(co),  64'(eco));
        check_val({tag, "_ovf"}, 64'(ovf), 64'(eovf));
        tick();
    endtask

    // Backpressure stream vectors and their hand-computed sums.
    logic [31:0] bp_a   [9] = '{32'd5, 32'd37, 32'd125, 32'd63, 32'd100, 32'd200, 32'd50, 32'd150, 32'd127};
    logic [31:0] bp_b   [9] = '{32'd10, 32'd48, 32'd110, 32'd211, 32'd33, 32'd47, 32'd43, 32'd150, 32'd127};
    logic        bp_ci  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] bp_exp [9] = '{32'd16, 32'd85, 32'd236, 32'd274, 32'd134, 32'd247, 32'd94, 32'd300, 32'd255};

    initial begin
        logic [33:0] exp_q [$];
        logic [33:0] e;
        logic [31:0] bp, out_s;
        logic [32:0] wide;
        logic        acc, cons, out_co, out_ovf, eo;
        int          idx, got, cyc, seen, sent;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; ci = 1'b0; sub = 1'b0;
        tick(); tick();
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_s",         64'(s),         64'd0);
        check_val("rst_co_ovf",    64'({co, ovf}), 64'd0);
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        tick();

        run_one("add_5_10",   32'd5,          32'd10,         1'b1, 1'b0, 32'd16,         1'b0, 1'b0);
        run_one("add_127",    32'd127,        32'd127,        1'b1, 1'b0, 32'd255,        1'b0, 1'b0);
        run_one("skip_ff_0",  32'hFFFF_FFFF,  32'h0000_0000,  1'b1, 1'b0, 32'h0000_0000,  1'b1, 1'b0);
        run_one("skip_ff_ff", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0);
        run_one("sub_37_48",  32'd37,         32'd48,         1'b1, 1'b1, 32'hFFFF_FFF5,  1'b0, 1'b0);
        run_one("sub_48_37",  32'd48,         32'd37,         1'b1, 1'b1, 32'd11,         1'b1, 1'b0);
        run_one("ovf_pos",    32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1);
        run_one("ovf_neg",    32'h8000_0000,  32'd1,          1'b1, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1);

        // Back-to-back stream with the consumer stalled for cycles 3..8.
        idx = 0; got = 0; cyc = 0;
        exp_q.delete();
        while (got < 9 && cyc < 80) begin
            out_ready = !(cyc >= 3 && cyc <= 8);
            in_valid  = (idx < 9);
            a   = (idx < 9) ? bp_a[idx]  : 32'd0;
            b   = (idx < 9) ? bp_b[idx]  : 32'd0;
            ci  = (idx < 9) ? bp_ci[idx] : 1'b0;
            sub = 1'b0;
            #1;
            if (out_valid && !out_ready) check_val("bp_stall_in_ready", 64'(in_ready), 64'd0);
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            out_s = s;
            tick();
            if (cons) begin
                if (exp_q.size() == 0) check_val("bp_extra_result", 64'(out_s), 64'hDEAD);
                else check_val("bp_result", 64'(out_s), 64'(exp_q.pop_front()));
                got++;
            end
            if (acc) begin
                exp_q.push_back(34'(bp_exp[idx]));
                idx++;
            end
            cyc++;
        end
        check_val("bp_count", 64'(got), 64'd9);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check_val("bp_no_dup", 64'(out_valid), 64'd0);

        // Reset while three operands are in flight.
        a = 32'd1; b = 32'd2; ci = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'd3; b = 32'd4;
        tick();
        a = 32'd5; b = 32'd6; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_s",         64'(s),         64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check_val("midrst_no_stale", 64'(seen), 64'd0);

        // Random traffic against an arithmetic golden model.
        exp_q.delete();
        sent = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0) && (sent < 200);
            out_ready = ($urandom_range(3) != 0);
            a   = $urandom;
            b   = $urandom;
            ci  = 1'($urandom_range(1));
            sub = 1'($urandom_range(1));
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            out_s = s; out_co = co; out_ovf = ovf;
            bp   = b ^ {32{sub}};
            wide = {1'b0, a} + {1'b0, bp} + {32'd0, ci};
            eo   = (a[31] == bp[31]) && (wide[31] != a[31]);
            tick();
            if (cons) begin
                if (exp_q.size() == 0) begin
                    check_val("rnd_extra_result", 64'(out_s), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rnd_result", 64'({out_ovf, out_co, out_s}), 64'(e));
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back({eo, wide[32], wide[31:0]});
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            cons = out_valid;
            out_s = s; out_co = co; out_ovf = ovf;
            tick();
            if (cons) begin
                if (exp_q.size() == 0) begin
                    check_val("rnd_extra_result", 64'(out_s), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rnd_result", 64'({out_ovf, out_co, out_s}), 64'(e));
                end
                got++;
            end
        end
        check_val("rnd_count", 64'(got), 64'(sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
